// File: rtl/vga_out_stage.sv
// VGA output stage: aligns timing to late colour, holds warm-up frames black,
// inserts a colour-bar test pattern and registers everything toward the DAC.
module vga_out_stage #(
    parameter int COLOR_LAT     = 1,
    parameter int HS_POL        = 0,
    parameter int VS_POL        = 0,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic        clk_pix,
    input  logic        resetn,
    input  logic [9:0]  x,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        active,
    input  logic [3:0]  r,
    input  logic [3:0]  g,
    input  logic [3:0]  b,
    input  logic        test_mode,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [15:0] frame_cnt,
    output logic        frame_start,
    output logic        running
);

    // Out-of-range parameters are clamped to the nearest legal value.
    localparam int LAT = (COLOR_LAT < 1) ? 1 :
                         (COLOR_LAT > 4) ? 4 : COLOR_LAT;

    localparam int WU_I = (WARMUP_FRAMES < 0)  ? 0  :
                          (WARMUP_FRAMES > 15) ? 15 : WARMUP_FRAMES;

    localparam logic [3:0] WU_N = 4'(WU_I);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    localparam logic ST_WARMUP = 1'b0;
    localparam logic ST_RUN    = 1'b1;

    // Timing delay line; index LAT-1 lines up with the incoming colour.
    logic [9:0] r_x_dl   [LAT];
    logic       r_hs_dl  [LAT];
    logic       r_vs_dl  [LAT];
    logic       r_act_dl [LAT];

    logic       r_vs_prev;
    logic       r_state;
    logic [3:0] r_wcnt;

    logic [3:0]  r_vga_r;
    logic [3:0]  r_vga_g;
    logic [3:0]  r_vga_b;
    logic        r_vga_hs;
    logic        r_vga_vs;
    logic [15:0] r_frame_cnt;
    logic        r_frame_start;
    logic        r_running;

    logic [9:0] w_x_d;
    logic       w_hs_d;
    logic       w_vs_d;
    logic       w_act_d;
    logic       w_fs;

    logic       w_state_nx;
    logic [3:0] w_wcnt_nx;
    logic [3:0] w_wcnt_inc;

    logic [2:0] w_bar_c;
    logic [3:0] w_col_r;
    logic [3:0] w_col_g;
    logic [3:0] w_col_b;

    // Shift the timing inputs down the delay line.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < LAT; i++) begin
                r_x_dl[i]   <= '0;
                r_hs_dl[i]  <= 1'b0;
                r_vs_dl[i]  <= 1'b0;
                r_act_dl[i] <= 1'b0;
            end
        end else begin
            r_x_dl[0]   <= x;
            r_hs_dl[0]  <= hsync;
            r_vs_dl[0]  <= vsync;
            r_act_dl[0] <= active;
            for (int i = 1; i < LAT; i++) begin
                r_x_dl[i]   <= r_x_dl[i-1];
                r_hs_dl[i]  <= r_hs_dl[i-1];
                r_vs_dl[i]  <= r_vs_dl[i-1];
                r_act_dl[i] <= r_act_dl[i-1];
            end
        end
    end

    assign w_x_d   = r_x_dl[LAT-1];
    assign w_hs_d  = r_hs_dl[LAT-1];
    assign w_vs_d  = r_vs_dl[LAT-1];
    assign w_act_d = r_act_dl[LAT-1];

    // A frame starts on the rising edge of the aligned vsync.
    assign w_fs = w_vs_d & ~r_vs_prev;

    // Warm-up sequencing: count frame starts until the target is reached.
    always_comb begin
        w_state_nx = r_state;
        w_wcnt_nx  = r_wcnt;
        w_wcnt_inc = r_wcnt + 4'd1;
        if (r_state == ST_WARMUP) begin
            if (WU_N == 4'd0) begin
                w_state_nx = ST_RUN;
            end else if (w_fs) begin
                w_wcnt_nx = w_wcnt_inc;
                if (w_wcnt_inc == WU_N) begin
                    w_state_nx = ST_RUN;
                end
            end
        end
    end

    // Colour-bar decode: eight 80-pixel bars, white down to black.
    always_comb begin
        w_bar_c = 3'd0;
        unique case (1'b1)
            (w_x_d < 10'd80):                      w_bar_c = 3'd7;
            (w_x_d >= 10'd80  && w_x_d < 10'd160): w_bar_c = 3'd6;
            (w_x_d >= 10'd160 && w_x_d < 10'd240): w_bar_c = 3'd5;
            (w_x_d >= 10'd240 && w_x_d < 10'd320): w_bar_c = 3'd4;
            (w_x_d >= 10'd320 && w_x_d < 10'd400): w_bar_c = 3'd3;
            (w_x_d >= 10'd400 && w_x_d < 10'd480): w_bar_c = 3'd2;
            (w_x_d >= 10'd480 && w_x_d < 10'd560): w_bar_c = 3'd1;
            default:                               w_bar_c = 3'd0;
        endcase
    end

    // Colour select: black unless running inside the visible area.
    always_comb begin
        w_col_r = 4'd0;
        w_col_g = 4'd0;
        w_col_b = 4'd0;
        if (r_state == ST_RUN && w_act_d) begin
            if (test_mode) begin
                w_col_r = {4{w_bar_c[2]}};
                w_col_g = {4{w_bar_c[1]}};
                w_col_b = {4{w_bar_c[0]}};
            end else begin
                w_col_r = r;
                w_col_g = g;
                w_col_b = b;
            end
        end
    end

    // Control state: vsync edge history, warm-up counter and FSM.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_vs_prev <= 1'b0;
            r_state   <= ST_WARMUP;
            r_wcnt    <= 4'd0;
            r_running <= 1'b0;
        end else begin
            r_vs_prev <= w_vs_d;
            r_state   <= w_state_nx;
            r_wcnt    <= w_wcnt_nx;
            r_running <= (w_state_nx == ST_RUN);
        end
    end

    // Frame counter and its start pulse move together.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_frame_cnt   <= 16'd0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_fs;
            if (w_fs) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    // DAC colour and sync registers.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_vga_r  <= 4'd0;
            r_vga_g  <= 4'd0;
            r_vga_b  <= 4'd0;
            r_vga_hs <= ~HS_ON;
            r_vga_vs <= ~VS_ON;
        end else begin
            r_vga_r  <= w_col_r;
            r_vga_g  <= w_col_g;
            r_vga_b  <= w_col_b;
            r_vga_hs <= w_hs_d ? HS_ON : ~HS_ON;
            r_vga_vs <= w_vs_d ? VS_ON : ~VS_ON;
        end
    end

    assign vga_r       = r_vga_r;
    assign vga_g       = r_vga_g;
    assign vga_b       = r_vga_b;
    assign vga_hsync   = r_vga_hs;
    assign vga_vsync   = r_vga_vs;
    assign frame_cnt   = r_frame_cnt;
    assign frame_start = r_frame_start;
    assign running     = r_running;

endmodule
